// File: rtl/reg_file_sb.sv
// Register file for the pipelined RV32I core: write-to-read bypass, trigger-forced register,
// and a per-register busy scoreboard that tracks outstanding loads for the hazard unit.
module reg_file_sb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int BYPASS      = 1,
  parameter int TRIGGER_REG = 5,
  parameter int OUT_REG     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  trigger,
  input  logic                  mark_valid,
  input  logic [ADDR_WIDTH-1:0] mark_rd,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TRIG_ADDR = ADDR_WIDTH'(TRIGGER_REG);
  localparam logic [ADDR_WIDTH-1:0] OUT_ADDR  = ADDR_WIDTH'(OUT_REG);
  localparam logic [DATA_WIDTH-1:0] TRIG_VAL  = DATA_WIDTH'(1);
  localparam bit TRIG_OK = (TRIGGER_REG != 0);
  localparam bit BYP_ON  = (BYPASS != 0);

  if (TRIGGER_REG >= NREGS || OUT_REG >= NREGS || TRIGGER_REG < 0 || OUT_REG < 0) begin : g_param_err
    $error("reg_file_sb: TRIGGER_REG and OUT_REG must index an existing register");
  end

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic                  wr_en_s;
  logic                  trig_en_s;
  logic                  mark_en_s;
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;
  logic                  busy1_s;
  logic                  busy2_s;

  assign wr_en_s   = RegWrite && (rd != '0);
  assign trig_en_s = trigger && TRIG_OK;
  assign mark_en_s = mark_valid && (mark_rd != '0);

  // Next register contents: trigger overrides a same-cycle write, x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s) begin
      regs_d[rd] = WD3;
    end else begin
      regs_d[0] = '0;
    end
    if (trig_en_s) begin
      regs_d[TRIG_ADDR] = TRIG_VAL;
    end else begin
      regs_d[0] = '0;
    end
    regs_d[0] = '0;
  end

  // Next scoreboard: a writeback clears, a new mark sets and wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_s) begin
      busy_d[rd] = 1'b0;
    end else begin
      busy_d[0] = 1'b0;
    end
    if (mark_en_s) begin
      busy_d[mark_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Storage and scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: trigger forward, then write forward, then storage.
  always_comb begin
    rd1_s   = regs_q[rs1];
    busy1_s = busy_q[rs1];
    if (BYP_ON && trig_en_s && (rs1 == TRIG_ADDR)) begin
      rd1_s = TRIG_VAL;
    end else if (BYP_ON && wr_en_s && (rd == rs1)) begin
      rd1_s = WD3;
    end else begin
      rd1_s = regs_q[rs1];
    end
    if (BYP_ON && wr_en_s && (rd == rs1) && !(mark_valid && (mark_rd == rs1))) begin
      busy1_s = 1'b0;
    end else begin
      busy1_s = busy_q[rs1];
    end
  end

  // Read port 2: same forwarding rules as port 1.
  always_comb begin
    rd2_s   = regs_q[rs2];
    busy2_s = busy_q[rs2];
    if (BYP_ON && trig_en_s && (rs2 == TRIG_ADDR)) begin
      rd2_s = TRIG_VAL;
    end else if (BYP_ON && wr_en_s && (rd == rs2)) begin
      rd2_s = WD3;
    end else begin
      rd2_s = regs_q[rs2];
    end
    if (BYP_ON && wr_en_s && (rd == rs2) && !(mark_valid && (mark_rd == rs2))) begin
      busy2_s = 1'b0;
    end else begin
      busy2_s = busy_q[rs2];
    end
  end

  // Forwarded values must not leak out while reset is held.
  assign RD1   = rst ? '0 : rd1_s;
  assign RD2   = rst ? '0 : rd2_s;
  assign busy1 = rst ? 1'b0 : busy1_s;
  assign busy2 = rst ? 1'b0 : busy2_s;
  assign a0    = rst ? '0 : regs_q[OUT_ADDR];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb: a bypassing instance checked from a table,
// a non-bypassing twin for the storage-only read path, and a mid-cycle reset sequence.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        trigger;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic [31:0] RD1, RD2, a0;
  logic        busy1, busy2;
  logic [31:0] nb_RD1, nb_RD2, nb_a0;
  logic        nb_busy1, nb_busy2;

  int errors = 0;
  int checks = 0;

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .TRIGGER_REG(5), .OUT_REG(10)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .rd(rd), .WD3(WD3), .rs1(rs1), .rs2(rs2),
    .trigger(trigger), .mark_valid(mark_valid), .mark_rd(mark_rd),
    .RD1(RD1), .RD2(RD2), .busy1(busy1), .busy2(busy2), .a0(a0)
  );

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .TRIGGER_REG(5), .OUT_REG(10)) dut_nb (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .rd(rd), .WD3(WD3), .rs1(rs1), .rs2(rs2),
    .trigger(trigger), .mark_valid(mark_valid), .mark_rd(mark_rd),
    .RD1(nb_RD1), .RD2(nb_RD2), .busy1(nb_busy1), .busy2(nb_busy2), .a0(nb_a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        trig;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_a0;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic we, input logic [4:0] rdv, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2, input logic tr,
                              input logic mv, input logic [4:0] mrd,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic b1, input logic b2, input logic [31:0] ea0);
    vec_t v;
    v.we = we; v.rd = rdv; v.wd = wd; v.rs1 = r1; v.rs2 = r2; v.trig = tr;
    v.mv = mv; v.mrd = mrd; v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_a0 = ea0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rdv, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic tr,
                       input logic mv, input logic [4:0] mrd);
    RegWrite = we; rd = rdv; WD3 = wd; rs1 = r1; rs2 = r2;
    trigger = tr; mark_valid = mv; mark_rd = mrd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

    //              we    rd     wd            rs1    rs2    tr    mv    mrd    RD1           RD2           b1    b2    a0
    tbl[0]  = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 5'd3,  32'h12345678, 5'd3,  5'd3,  1'b0, 1'b0, 5'd0,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b0, 1'b0, 5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0);
    tbl[5]  = mk(1'b1, 5'd5,  32'hAA,       5'd5,  5'd5,  1'b1, 1'b0, 5'd0,  32'h1,        32'h1,        1'b0, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  1'b0, 1'b0, 5'd0,  32'h1,        32'h1,        1'b0, 1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 5'd5,  32'hAA,       5'd5,  5'd3,  1'b0, 1'b0, 5'd0,  32'hAA,       32'h12345678, 1'b0, 1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 1'b0, 5'd0,  32'hAA,       32'h0,        1'b0, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b0, 1'b1, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 32'h0);
    tbl[11] = mk(1'b1, 5'd7,  32'h77,       5'd7,  5'd0,  1'b0, 1'b1, 5'd7,  32'h77,       32'h0,        1'b1, 1'b0, 32'h0);
    tbl[12] = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 1'b0, 5'd0,  32'h77,       32'h0,        1'b1, 1'b0, 32'h0);
    tbl[13] = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 1'b1, 5'd7,  32'h77,       32'h0,        1'b1, 1'b0, 32'h0);
    tbl[14] = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 1'b0, 5'd0,  32'h77,       32'h0,        1'b1, 1'b0, 32'h0);
    tbl[15] = mk(1'b1, 5'd7,  32'h700,      5'd7,  5'd7,  1'b0, 1'b0, 5'd0,  32'h700,      32'h700,      1'b0, 1'b0, 32'h0);
    tbl[16] = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b0, 1'b0, 5'd0,  32'h700,      32'h700,      1'b0, 1'b0, 32'h0);
    tbl[17] = mk(1'b1, 5'd10, 32'h42,       5'd10, 5'd0,  1'b0, 1'b0, 5'd0,  32'h42,       32'h0,        1'b0, 1'b0, 32'h0);
    tbl[18] = mk(1'b0, 5'd0,  32'h0,        5'd10, 5'd0,  1'b0, 1'b0, 5'd0,  32'h42,       32'h0,        1'b0, 1'b0, 32'h42);
    tbl[19] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b1, 1'b0, 5'd0,  32'h0,        32'h1,        1'b0, 1'b0, 32'h42);
    tbl[20] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b0, 1'b0, 5'd0,  32'h0,        32'h1,        1'b0, 1'b0, 32'h42);
    tbl[21] = mk(1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  32'h0,        32'h0,        1'b0, 1'b0, 32'h42);
    tbl[22] = mk(1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  1'b0, 1'b0, 5'd0,  32'h0,        32'h700,      1'b1, 1'b0, 32'h42);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].rs1, tbl[i].rs2, tbl[i].trig, tbl[i].mv, tbl[i].mrd);
      #3;
      check($sformatf("vec%0d RD1", i), RD1, tbl[i].e_rd1);
      check($sformatf("vec%0d RD2", i), RD2, tbl[i].e_rd2);
      check($sformatf("vec%0d busy1", i), {31'b0, busy1}, {31'b0, tbl[i].e_b1});
      check($sformatf("vec%0d busy2", i), {31'b0, busy2}, {31'b0, tbl[i].e_b2});
      check($sformatf("vec%0d a0", i), a0, tbl[i].e_a0);
      next_cycle();
    end

    // Storage-only reads on the BYPASS=0 twin versus the bypassing instance.
    drive(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    #3;
    check("byp1 write-cycle RD1", RD1, 32'hCAFEF00D);
    check("nobyp write-cycle RD1", nb_RD1, 32'h12345678);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    #3;
    check("nobyp next-cycle RD1", nb_RD1, 32'hCAFEF00D);
    next_cycle();
    drive(1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    #3;
    check("byp1 clear busy1", {31'b0, busy1}, 32'h0);
    check("nobyp clear busy1", {31'b0, nb_busy1}, 32'h1);
    check("nobyp write-cycle RD1 x9", nb_RD1, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    #3;
    check("nobyp busy1 after clear", {31'b0, nb_busy1}, 32'h0);
    check("nobyp RD1 x9 after write", nb_RD1, 32'h9);
    next_cycle();

    // Asynchronous reset in the middle of a write cycle.
    drive(1'b1, 5'd1, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 1'b1, 5'd2);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0);
    #2;
    check("pre-reset RD1 x1", RD1, 32'hDEADBEEF);
    check("pre-reset busy2 x2", {31'b0, busy2}, 32'h1);
    drive(1'b1, 5'd1, 32'h1111, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3);
    rst = 1'b1;
    #1;
    check("in-reset RD1", RD1, 32'h0);
    check("in-reset RD2", RD2, 32'h0);
    check("in-reset busy2", {31'b0, busy2}, 32'h0);
    check("in-reset a0", a0, 32'h0);
    check("in-reset nobyp RD1", nb_RD1, 32'h0);
    next_cycle();
    check("reset-edge RD1", RD1, 32'h0);
    check("reset-edge a0", a0, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd5, 1'b0, 1'b0, 5'd0);
    #2;
    rst = 1'b0;
    #1;
    check("post-reset RD1 x1", RD1, 32'h0);
    check("post-reset RD2 x5", RD2, 32'h0);
    check("post-reset a0", a0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd3, 1'b0, 1'b0, 5'd0);
    #3;
    check("post-reset busy1 x2", {31'b0, busy1}, 32'h0);
    check("post-reset busy2 x3", {31'b0, busy2}, 32'h0);
    check("post-reset nobyp RD1 x2", nb_RD1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
